// File: rtl/timer_multi.sv
// timer_multi: NUM_CH independent timer channels behind the MMIO slot bus.
// Each channel has a prescaler, an up/down counter with optional auto-reload,
// a compare register, sticky W1C status flags and a level interrupt.
//
// Ports:
//   clk, arst              clock, asynchronous active-high reset
//   chip_select/read/write slot request (write wins if both are high)
//   transaction_completed  master ack; releases the DONE state
//   addr[7:5]              channel index; addr[4:0] register offset
//   wr_data                write data (truncated to the register width)
//   rd_data                registered read data, zero-extended
//   wr_done, rd_done       one-cycle completion pulses (first DONE cycle)
//   idle                   high while the slot FSM is in IDLE
//   slave_error            write to read-only COUNT
//   decode_error           unmapped channel or offset
//   irq[NUM_CH]            per-channel registered level interrupt
//
// Handshake: a request is accepted only in IDLE when chip_select and read or
// write are high; the access executes in the single ACTIVE cycle; results are
// visible from the first DONE cycle and rd_data/error flags hold until the
// master raises transaction_completed, which returns the slot to IDLE.
module timer_multi #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              chip_select,
  input  logic              read,
  input  logic              write,
  input  logic              transaction_completed,
  input  logic [7:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              wr_done,
  output logic              rd_done,
  output logic              idle,
  output logic              slave_error,
  output logic              decode_error,
  output logic [NUM_CH-1:0] irq
);

  localparam logic [4:0] OFF_COUNT  = 5'h00;
  localparam logic [4:0] OFF_ARR    = 5'h04;
  localparam logic [4:0] OFF_CTRL   = 5'h08;
  localparam logic [4:0] OFF_PRESC  = 5'h0C;
  localparam logic [4:0] OFF_STATUS = 5'h10;
  localparam logic [4:0] OFF_CMP    = 5'h14;

  localparam logic [3:0]         NUM_CH_L = 4'(NUM_CH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PRESC_W-1:0] PC_ONE   = PRESC_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t state, state_next;
  logic   exec;

  // Captured request
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;

  // Channel state
  logic [CNT_W-1:0]   count_q [NUM_CH];
  logic [CNT_W-1:0]   arr_q   [NUM_CH];
  logic [CNT_W-1:0]   cmp_q   [NUM_CH];
  logic [PRESC_W-1:0] presc_q [NUM_CH];
  logic [PRESC_W-1:0] pc_q    [NUM_CH];
  logic [NUM_CH-1:0]  en_q, down_q, reload_q, irq_en_q, uf_q, cf_q;

  // Per-channel counting results for this cycle
  logic [CNT_W-1:0]   count_nxt [NUM_CH];
  logic [PRESC_W-1:0] pc_nxt    [NUM_CH];
  logic [NUM_CH-1:0]  tick, en_nxt, uf_set, cf_set, wr_hit;

  // Decode of the captured request
  logic [2:0]  ch_sel;
  logic [4:0]  off;
  logic        ch_ok, off_ok, dec_err, slv_err, wr_ok;
  logic [31:0] rd_val;

  wire start = chip_select && (read || write);

  function automatic logic [31:0] ext_cnt(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  function automatic logic [31:0] ext_presc(input logic [PRESC_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[PRESC_W-1:0] = v;
    return r;
  endfunction

  // ---------------- slot FSM: state register ----------------
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= state_next;
  end

  // ---------------- slot FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_ACTIVE;
      S_ACTIVE: state_next = S_DONE;
      S_DONE:   if (transaction_completed) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------- slot FSM: outputs ----------------
  always_comb begin
    idle = (state == S_IDLE);
    exec = (state == S_ACTIVE);
  end

  // Request capture; inputs are ignored outside IDLE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      req_write <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
    end else if (state == S_IDLE && start) begin
      req_write <= write;
      req_addr  <= addr;
      req_wdata <= wr_data;
    end
  end

  // ---------------- address decode and read mux ----------------
  always_comb begin
    ch_sel  = req_addr[7:5];
    off     = req_addr[4:0];
    ch_ok   = ({1'b0, ch_sel} < NUM_CH_L);
    off_ok  = (off == OFF_COUNT) || (off == OFF_ARR) || (off == OFF_CTRL) ||
              (off == OFF_PRESC) || (off == OFF_STATUS) || (off == OFF_CMP);
    dec_err = !(ch_ok && off_ok);
    slv_err = !dec_err && req_write && (off == OFF_COUNT);
    wr_ok   = exec && req_write && !dec_err && !slv_err;
    wr_hit  = '0;
    rd_val  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 3'(i)) begin
        wr_hit[i] = wr_ok;
        case (off)
          OFF_COUNT:  rd_val = ext_cnt(count_q[i]);
          OFF_ARR:    rd_val = ext_cnt(arr_q[i]);
          OFF_CTRL:   rd_val = {28'h0, irq_en_q[i], reload_q[i], down_q[i], en_q[i]};
          OFF_PRESC:  rd_val = ext_presc(presc_q[i]);
          OFF_STATUS: rd_val = {29'h0, cf_q[i], uf_q[i], en_q[i]};
          OFF_CMP:    rd_val = ext_cnt(cmp_q[i]);
          default:    rd_val = '0;
        endcase
      end
    end
  end

  // Bus response registers: loaded in ACTIVE, visible from the first DONE cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rd_data      <= '0;
      wr_done      <= 1'b0;
      rd_done      <= 1'b0;
      slave_error  <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (exec) begin
        wr_done      <= req_write;
        rd_done      <= !req_write;
        slave_error  <= slv_err;
        decode_error <= dec_err;
        if (!req_write) rd_data <= dec_err ? 32'h0 : rd_val;
      end else if (state == S_DONE && transaction_completed) begin
        slave_error  <= 1'b0;
        decode_error <= 1'b0;
      end
    end
  end

  // ---------------- channel counting ----------------
  always_comb begin
    tick      = '0;
    en_nxt    = en_q;
    uf_set    = '0;
    cf_set    = '0;
    count_nxt = count_q;
    pc_nxt    = pc_q;
    for (int i = 0; i < NUM_CH; i++) begin
      tick[i] = en_q[i] && (pc_q[i] == presc_q[i]);
      if (en_q[i]) pc_nxt[i] = tick[i] ? '0 : pc_q[i] + PC_ONE;
      // Compare uses the counter value before this tick's update.
      cf_set[i] = tick[i] && (count_q[i] == cmp_q[i]);
      if (tick[i]) begin
        if (down_q[i]) begin
          if (count_q[i] == '0) begin
            uf_set[i] = 1'b1;
            if (reload_q[i]) count_nxt[i] = arr_q[i];
            else             en_nxt[i]    = 1'b0;
          end else begin
            count_nxt[i] = count_q[i] - CNT_ONE;
          end
        end else begin
          // >= so a counter already past a lowered ARR terminates at once.
          if (count_q[i] >= arr_q[i]) begin
            uf_set[i] = 1'b1;
            if (reload_q[i]) count_nxt[i] = '0;
            else             en_nxt[i]    = 1'b0;
          end else begin
            count_nxt[i] = count_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Channel registers. Counting updates come first; a register write in
  // the same cycle overrides them, except flag events, which beat W1C.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= '0;
        arr_q[i]   <= '0;
        cmp_q[i]   <= '0;
        presc_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      en_q     <= '0;
      down_q   <= '0;
      reload_q <= '0;
      irq_en_q <= '0;
      uf_q     <= '0;
      cf_q     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        count_q[i] <= count_nxt[i];
        pc_q[i]    <= pc_nxt[i];
        en_q[i]    <= en_nxt[i];
        uf_q[i]    <= uf_q[i] | uf_set[i];
        cf_q[i]    <= cf_q[i] | cf_set[i];
        if (wr_hit[i]) begin
          case (off)
            OFF_ARR:   arr_q[i]   <= req_wdata[CNT_W-1:0];
            OFF_PRESC: presc_q[i] <= req_wdata[PRESC_W-1:0];
            OFF_CMP:   cmp_q[i]   <= req_wdata[CNT_W-1:0];
            OFF_CTRL: begin
              en_q[i]     <= req_wdata[0];
              down_q[i]   <= req_wdata[1];
              reload_q[i] <= req_wdata[2];
              irq_en_q[i] <= req_wdata[3];
              // Rising enable restarts the channel from its start value.
              if (!en_q[i] && req_wdata[0]) begin
                pc_q[i]    <= '0;
                count_q[i] <= req_wdata[1] ? arr_q[i] : '0;
              end
            end
            OFF_STATUS: begin
              uf_q[i] <= (uf_q[i] & ~req_wdata[1]) | uf_set[i];
              cf_q[i] <= (cf_q[i] & ~req_wdata[2]) | cf_set[i];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Interrupt lags the flags by one cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) irq <= '0;
    else      irq <= irq_en_q & (uf_q | cf_q);
  end

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi (default parameters: 4 channels).
// Bus accesses start on a falling edge and take three cycles; the access
// executes on the second rising edge after it is driven. Expected responses
// are queued when an access is driven and compared by a monitor when the
// DUT pulses rd_done/wr_done.
module tb_timer_multi;

  logic        clk = 1'b0;
  logic        arst;
  logic        chip_select, read, write, transaction_completed;
  logic [7:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        wr_done, rd_done, idle, slave_error, decode_error;
  logic [3:0]  irq;

  int n_checks = 0;
  int n_pass   = 0;

  // {rd_done, wr_done, slave_error, decode_error, rd_data}
  logic [35:0] exp_q[$];
  string       tag_q[$];
  logic [35:0] mon_exp;
  string       mon_tag;

  timer_multi #(.NUM_CH(4), .CNT_W(32), .PRESC_W(16)) dut (
    .clk                   (clk),
    .arst                  (arst),
    .chip_select           (chip_select),
    .read                  (read),
    .write                 (write),
    .transaction_completed (transaction_completed),
    .addr                  (addr),
    .wr_data               (wr_data),
    .rd_data               (rd_data),
    .wr_done               (wr_done),
    .rd_done               (rd_done),
    .idle                  (idle),
    .slave_error           (slave_error),
    .decode_error          (decode_error),
    .irq                   (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!arst && (rd_done || wr_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {62'h0, rd_done, wr_done}, 64'h0);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        check(mon_tag, {28'h0, rd_done, wr_done, slave_error, decode_error,
                        (wr_done ? 32'h0 : rd_data)}, {28'h0, mon_exp});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic bus_access(input logic is_wr, input logic [7:0] a, input logic [31:0] d,
                            input logic [31:0] exp_data, input logic exp_slv,
                            input logic exp_dec, input int hold, input string tag);
    exp_q.push_back({~is_wr, is_wr, exp_slv, exp_dec, (is_wr ? 32'h0 : exp_data)});
    tag_q.push_back(tag);
    chip_select = 1'b1;
    read        = ~is_wr;
    write       = is_wr;
    addr        = a;
    wr_data     = d;
    @(negedge clk);
    chip_select = 1'b0;
    read        = 1'b0;
    write       = 1'b0;
    @(negedge clk);  // first DONE cycle: monitor compares here
    repeat (hold) @(negedge clk);
    if (hold > 0)
      check({tag, "_held"}, {59'h0, idle, rd_done, wr_done, slave_error, decode_error},
            {59'h0, 1'b0, 1'b0, 1'b0, exp_slv, exp_dec});
    transaction_completed = 1'b1;
    @(negedge clk);
    transaction_completed = 1'b0;
    if (exp_slv || exp_dec || hold > 0)
      check({tag, "_release"}, {61'h0, idle, slave_error, decode_error}, 64'h4);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string tag);
    bus_access(1'b1, a, d, 32'h0, 1'b0, 1'b0, 0, tag);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string tag);
    bus_access(1'b0, a, 32'h0, exp, 1'b0, 1'b0, 0, tag);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    arst = 1'b1;
    chip_select = 1'b0; read = 1'b0; write = 1'b0;
    transaction_completed = 1'b0;
    addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {23'h0, rd_data, wr_done, rd_done, idle, slave_error, decode_error, irq},
          {23'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
    arst = 1'b0;
    @(negedge clk);

    // 1: ch0 up, auto-reload, ARR=3 -> count wraps modulo 4, one tick/cycle.
    wr(8'h04, 32'd3,   "t1_arr");
    wr(8'h0C, 32'd0,   "t1_presc");
    wr(8'h14, 32'd100, "t1_cmp");
    wr(8'h08, 32'h5,   "t1_ctrl");
    // Read k samples the count 2+3k ticks after enable.
    for (int k = 0; k < 6; k++) rd(8'h00, 32'((2 + 3 * k) % 4), "t1_count");
    rd(8'h10, 32'h3, "t1_status");
    wr(8'h04, 32'd1000, "t1_arr_big");
    wr(8'h10, 32'h2,    "t1_w1c_uf");
    rd(8'h10, 32'h1,    "t1_status_w1c");
    wr(8'h08, 32'h0,    "t1_disable");

    // 2: ch1 down, no reload, PRESC=2 -> 2,1,0 every 3 cycles, then stop.
    wr(8'h24, 32'd2, "t2_arr");
    wr(8'h2C, 32'd2, "t2_presc");
    wr(8'h34, 32'd7, "t2_cmp");
    wr(8'h28, 32'h3, "t2_ctrl");
    rd(8'h20, 32'd2, "t2_count_a");
    rd(8'h20, 32'd1, "t2_count_b");
    rd(8'h20, 32'd0, "t2_count_c");
    rd(8'h20, 32'd0, "t2_count_hold");
    rd(8'h30, 32'h2, "t2_status");

    // 3: ch2 compare at 5 with interrupt; irq one cycle after cf.
    wr(8'h54, 32'd5,  "t3_cmp");
    wr(8'h44, 32'd10, "t3_arr");
    wr(8'h48, 32'hD,  "t3_ctrl");
    n = 0;
    while (!irq[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t3_irq_latency", 64'(n), 64'd6);
    check("t3_irq_bits", {60'h0, irq}, 64'h4);
    wr(8'h50, 32'h4, "t3_w1c_cf");
    check("t3_irq_drop", {60'h0, irq}, 64'h0);
    wr(8'h48, 32'h0, "t3_disable");
    rd(8'h50, 32'h2, "t3_status");

    // 4: error responses.
    bus_access(1'b1, 8'h40, 32'h1234, 32'h0, 1'b1, 1'b0, 2, "t4_wr_count");
    rd(8'h40, 32'd1, "t4_count_kept");
    bus_access(1'b0, 8'h18, 32'h0, 32'h0, 1'b0, 1'b1, 1, "t4_rd_bad_off");
    bus_access(1'b0, 8'h80, 32'h0, 32'h0, 1'b0, 1'b1, 0, "t4_rd_bad_ch");
    bus_access(1'b1, 8'h9C, 32'hFF, 32'h0, 1'b0, 1'b1, 0, "t4_wr_bad");

    // 5a: W1C of uf landing on a wrap keeps uf set (ch3, wraps every 4).
    wr(8'h64, 32'd3,   "t5_arr");
    wr(8'h6C, 32'd0,   "t5_presc");
    wr(8'h74, 32'd100, "t5_cmp");
    wr(8'h68, 32'h5,   "t5_ctrl");
    rd(8'h60, 32'd2, "t5_count_a");
    rd(8'h60, 32'd1, "t5_count_b");
    rd(8'h60, 32'd0, "t5_count_c");
    wr(8'h70, 32'h2, "t5_w1c_collide");
    rd(8'h70, 32'h3, "t5_status_collide");

    // 5b: lower ARR below a running up-counter (PRESC=3, tick every 4).
    wr(8'h68, 32'h0,  "t5_disable");
    wr(8'h70, 32'h6,  "t5_clear");
    wr(8'h64, 32'd20, "t5_arr20");
    wr(8'h6C, 32'd3,  "t5_presc3");
    wr(8'h68, 32'h5,  "t5_ctrl2");
    wait_cycles(24);
    rd(8'h60, 32'd6,  "t5_count_6");
    wr(8'h64, 32'd1,  "t5_arr1");
    rd(8'h60, 32'd0,  "t5_count_wrap");
    rd(8'h70, 32'h3,  "t5_status_uf");

    // 6: reset while in DONE with rd_data=0xABCD.
    wr(8'h04, 32'hABCD, "t6_arr");
    exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD});
    tag_q.push_back("t6_rd");
    chip_select = 1'b1; read = 1'b1; addr = 8'h04;
    @(negedge clk);
    chip_select = 1'b0; read = 1'b0;
    @(negedge clk);
    #2 arst = 1'b1;
    #1;
    check("t6_reset_outputs", {23'h0, rd_data, wr_done, rd_done, idle, slave_error, decode_error, irq},
          {23'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});
    @(negedge clk);
    arst = 1'b0;
    rd(8'h00, 32'd0, "t6_count0");
    rd(8'h20, 32'd0, "t6_count1");
    rd(8'h40, 32'd0, "t6_count2");
    rd(8'h60, 32'd0, "t6_count3");
    rd(8'h04, 32'd0, "t6_arr0");
    wait_cycles(10);
    rd(8'h60, 32'd0, "t6_still0");
    wr(8'h04, 32'd5, "t6_arr5");
    wr(8'h08, 32'h1, "t6_ctrl");
    rd(8'h00, 32'd2, "t6_resume");

    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
Parametrised multi-channel successor to the single-channel MMIO timer. It provides NUM_CH independent counters, each with its own prescaler, auto-reload, compare match, sticky W1C status flags and a per-channel interrupt. It sits on the MMIO slot bus behind the same three-state slot handshake used by the other MMIO peripherals.

Parameters:
NUM_CH, 4, number of timer channels (1..8)
CNT_W, 32, counter/ARR/CMP width in bits (1..32)
PRESC_W, 16, prescaler register width in bits (1..32)

Ports:
clk  in  1  system clock
arst  in  1  asynchronous active-high reset
chip_select  in  1  slot select
read  in  1  read request
write  in  1  write request (write wins if both high)
transaction_completed  in  1  master ack; releases DONE
addr  in  8  addr[7:5] = channel, addr[4:0] = register offset
wr_data  in  32  write data
rd_data  out  32  registered read data, zero-extended
wr_done  out  1  one-cycle write-done pulse
rd_done  out  1  one-cycle read-done pulse
idle  out  1  high while the slot FSM is in IDLE
slave_error  out  1  illegal access to a valid register
decode_error  out  1  unmapped address
irq  out  NUM_CH  per-channel level interrupt

Behaviour:
- Clocking and reset: single clock clk. Reset arst is asynchronous and active-high. Reset values: rd_data=0, wr_done=0, rd_done=0, slave_error=0, decode_error=0, irq=0, idle=1. All channel registers reset to 0.
- Per-channel register map (offsets):
  - 0x00 COUNT: read-only.
  - 0x04 ARR: read/write.
  - 0x08 CTRL: read/write. Bit0 en, bit1 down, bit2 auto_reload, bit3 irq_en.
  - 0x0C PRESC: read/write.
  - 0x10 STATUS: bit0 en (read-only), bit1 update flag uf, bit2 compare flag cf. Writing 1 to uf/cf clears it (W1C).
  - 0x14 CMP: read/write.
- Decode errors: a channel index >= NUM_CH, or any offset not listed above, raises decode_error. No state changes.
- Slave errors: a write to COUNT raises slave_error. No state changes.
- Widths: on write, wr_data is truncated to the register width. On read, the value is zero-extended to 32 bits.
- Slot FSM states: IDLE, ACTIVE, DONE.
  - IDLE -> ACTIVE when chip_select && (read || write). The request is captured in this cycle.
  - ACTIVE -> DONE unconditionally. The register access executes in ACTIVE.
  - The ACTIVE cycle registers rd_data, the done pulse and the error flags, so they are visible in the first DONE cycle.
  - rd_done/wr_done are high for exactly that one cycle.
  - rd_data and the error flags hold until DONE -> IDLE, which happens when transaction_completed is high.
  - Error flags clear on IDLE entry. Errors still produce a done pulse.
  - Request inputs are ignored outside IDLE.
- Prescaler: each channel has a prescaler count pc. While en=1, pc increments each cycle; when pc==PRESC, tick=1 and pc<=0. PRESC=0 therefore ticks every cycle.
- Counting, up mode, on tick:
  - If COUNT>=ARR: set uf. If auto_reload, COUNT<=0; otherwise COUNT holds and en clears.
  - Otherwise COUNT<=COUNT+1.
- Counting, down mode, on tick:
  - If COUNT==0: set uf. If auto_reload, COUNT<=ARR; otherwise hold and en clears.
  - Otherwise COUNT<=COUNT-1.
- Compare: on tick, if the pre-update COUNT==CMP, set cf.
- Enable/disable:
  - A CTRL write that changes en 0->1 clears pc and loads COUNT with 0 (up) or ARR (down).
  - Writing en=0 freezes COUNT and pc.
- Run-time ARR writes take effect on the next tick. An up-counter already above the new ARR terminates on its next tick (>= compare).
- W1C collision: a W1C clear and a new flag event in the same cycle leave the flag set (event wins).
- irq[i] = irq_en[i] && (uf[i] || cf[i]), registered (one-cycle latency after the flag sets).
- Channels are fully independent. A bus access to one channel never stalls counting in another.
- Reset mid-transaction: the FSM returns to IDLE and all outputs take their reset values immediately.

Test Plan:
1. Write ARR=3, PRESC=0, CTRL=0x5 (en, up, auto_reload) on ch0 -> COUNT sequence 0,1,2,3,0,1..., uf sets at the first wrap. Reading STATUS returns 0x3. Writing STATUS=0x2 then reading returns 0x1.
2. ch1: ARR=2, PRESC=2, CTRL=0x3 (en, down, no reload) -> COUNT 2,1,0 changing every 3 cycles. uf sets, then en clears and STATUS reads 0x2. COUNT holds 0.
3. ch2: CMP=5, ARR=10, CTRL=0xD (en, reload, irq_en) -> cf sets and irq[2] rises one cycle after COUNT 5->6. W1C 0x4 drops irq[2]. Other irq bits stay 0.
4. Write COUNT (addr 0x40) -> wr_done pulse with slave_error=1 held until transaction_completed, COUNT unchanged. Read addr 0x18 -> decode_error=1, rd_done pulse, rd_data=0. Read with NUM_CH=4 at addr 0x80 -> decode_error=1.
5. Issue a W1C of uf in the same cycle as a wrap event -> uf remains 1. Write ARR=1 while an up-counter is at 7 -> uf sets on the next tick and COUNT goes to 0.
6. Assert arst while in DONE with rd_data=0xABCD -> rd_data=0, errors=0, idle=1 and all counters 0 in the same cycle. Counting resumes only after a new CTRL write.
